// File: rtl/fb_arbiter.sv
// Frame-buffer RAM arbiter: one RAM port shared between a raster-order pixel
// writer and a random-access scanout reader, with write-starvation protection.

module fb_arbiter_chk #(
    parameter int STARVE_LIMIT = 8
) (
    input logic        CLOCK_100,
    input logic        reset_N,
    input logic        mem_en,
    input logic        mem_we,
    input logic        pix_ready,
    input logic        rd_valid,
    input logic [15:0] rd_data,
    input logic [3:0]  starve_cnt
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    a_we_is_write_grant : assert property (@(posedge CLOCK_100) disable iff (!reset_N)
        mem_we |-> (mem_en && pix_ready));

    a_idle_data_zero : assert property (@(posedge CLOCK_100) disable iff (!reset_N)
        !rd_valid |-> (rd_data == 16'h0000));

    a_starve_bounded : assert property (@(posedge CLOCK_100) disable iff (!reset_N)
        starve_cnt <= STARVE_MAX);

endmodule

module fb_arbiter #(
    parameter int H_ACTIVE     = 336,
    parameter int V_ACTIVE     = 240,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        CLOCK_100,
    input  logic        reset_N,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic [8:0]  wr_col,
    output logic [7:0]  wr_row,
    output logic        frame_done,
    input  logic        rd_req,
    input  logic [9:0]  rd_col,
    input  logic [8:0]  rd_row,
    output logic        rd_gnt,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        mem_en,
    output logic        mem_we,
    output logic [16:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [9:0] RD_COL_LIM = 10'(H_ACTIVE);
    localparam logic [8:0] RD_ROW_LIM = 9'(V_ACTIVE);
    localparam logic [8:0] COL_LAST   = 9'(H_ACTIVE - 1);
    localparam logic [7:0] ROW_LAST   = 8'(V_ACTIVE - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // row*336 + col built as row*(256+64+16) + col
    function automatic logic [16:0] pix_addr(input logic [7:0] row, input logic [8:0] col);
        pix_addr = {1'b0, row, 8'h00} + {3'b000, row, 6'h00}
                 + {5'b00000, row, 4'h0} + {8'h00, col};
    endfunction

    logic        rd_in_range_s;
    logic        rd_gnt_in_s;
    logic        rd_gnt_oor_s;
    logic        wr_gnt_s;
    logic [8:0]  wr_col_nx_s;
    logic [7:0]  wr_row_nx_s;
    logic        frame_end_s;
    logic [3:0]  starve_nx_s;

    logic [8:0]  wr_col_r;
    logic [7:0]  wr_row_r;
    logic [3:0]  starve_cnt_r;
    logic        frame_done_r;
    logic        rd_p1_vld_r;
    logic        rd_p1_oor_r;
    logic        rd_valid_r;
    logic [15:0] rd_data_r;

    // Per-cycle grant decision; nothing is granted while reset is sampled low
    always_comb begin
        rd_in_range_s = (rd_col < RD_COL_LIM) && (rd_row < RD_ROW_LIM);
        rd_gnt_in_s   = 1'b0;
        rd_gnt_oor_s  = 1'b0;
        wr_gnt_s      = 1'b0;
        if (reset_N) begin
            rd_gnt_in_s  = rd_req && rd_in_range_s &&
                           ((starve_cnt_r < STARVE_MAX) || !pix_valid);
            rd_gnt_oor_s = rd_req && !rd_in_range_s;
            wr_gnt_s     = pix_valid && !rd_gnt_in_s;
        end else begin
            rd_gnt_in_s  = 1'b0;
            rd_gnt_oor_s = 1'b0;
            wr_gnt_s     = 1'b0;
        end
    end

    // RAM strobe driven straight from the grant; out-of-range reads never touch RAM
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 17'h00000;
        mem_wdata = 16'h0000;
        if (rd_gnt_in_s) begin
            mem_en   = 1'b1;
            mem_addr = pix_addr(rd_row[7:0], rd_col[8:0]);
        end else if (wr_gnt_s) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = pix_sof ? 17'h00000 : pix_addr(wr_row_r, wr_col_r);
            mem_wdata = pix_data;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Raster position advance; an SOF pixel lands at (0,0) so the next one is (1,0)
    always_comb begin
        wr_col_nx_s = wr_col_r;
        wr_row_nx_s = wr_row_r;
        frame_end_s = 1'b0;
        if (wr_gnt_s) begin
            if (pix_sof) begin
                wr_col_nx_s = 9'd1;
                wr_row_nx_s = 8'd0;
            end else if (wr_col_r == COL_LAST) begin
                wr_col_nx_s = 9'd0;
                if (wr_row_r == ROW_LAST) begin
                    wr_row_nx_s = 8'd0;
                    frame_end_s = 1'b1;
                end else begin
                    wr_row_nx_s = wr_row_r + 8'd1;
                end
            end else begin
                wr_col_nx_s = wr_col_r + 9'd1;
            end
        end else begin
            frame_end_s = 1'b0;
        end
    end

    // Consecutive in-range read grants while a pixel is waiting
    always_comb begin
        starve_nx_s = starve_cnt_r;
        if (wr_gnt_s || !pix_valid) begin
            starve_nx_s = 4'd0;
        end else if (rd_gnt_in_s && (starve_cnt_r < STARVE_MAX)) begin
            starve_nx_s = starve_cnt_r + 4'd1;
        end else begin
            starve_nx_s = starve_cnt_r;
        end
    end

    // State and two-stage read-return pipeline
    always_ff @(posedge CLOCK_100) begin
        if (!reset_N) begin
            wr_col_r     <= 9'd0;
            wr_row_r     <= 8'd0;
            starve_cnt_r <= 4'd0;
            frame_done_r <= 1'b0;
            rd_p1_vld_r  <= 1'b0;
            rd_p1_oor_r  <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_data_r    <= 16'h0000;
        end else begin
            wr_col_r     <= wr_col_nx_s;
            wr_row_r     <= wr_row_nx_s;
            starve_cnt_r <= starve_nx_s;
            frame_done_r <= frame_end_s;
            rd_p1_vld_r  <= rd_gnt_in_s | rd_gnt_oor_s;
            rd_p1_oor_r  <= rd_gnt_oor_s;
            rd_valid_r   <= rd_p1_vld_r;
            rd_data_r    <= (rd_p1_vld_r && !rd_p1_oor_r) ? mem_rdata : 16'h0000;
        end
    end

    assign pix_ready  = wr_gnt_s;
    assign rd_gnt     = rd_gnt_in_s | rd_gnt_oor_s;
    assign wr_col     = wr_col_r;
    assign wr_row     = wr_row_r;
    assign frame_done = frame_done_r;
    assign rd_valid   = rd_valid_r;
    assign rd_data    = rd_data_r;

    fb_arbiter_chk #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_chk (
        .CLOCK_100  (CLOCK_100),
        .reset_N    (reset_N),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .pix_ready  (pix_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .starve_cnt (starve_cnt_r)
    );

endmodule
